minbd_local_ni: RTL and testbench

Local network interface on the node side of a minBD router. It queues core-issued flits and drives the router's local injection input (`din_l`) with a stop-and-wait offer protocol paced by the registered `local_inject_gnt`. It also absorbs up to two ejected flits per cycle from `dout_l_1`/`dout_l_2` into an ejection FIFO and drains them to the core over valid/ready. The router is bufferless and cannot be back-pressured on ejection, so overflow is detected and flagged, never stalled.

---
 rtl/minbd_local_ni_pkg.sv | 27 ++
 rtl/minbd_local_ni_dual_wr_fifo.sv | 87 ++++++++
 rtl/minbd_local_ni.sv | 198 +++++++++++++++++++
 tb/tb_minbd_local_ni.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minbd_local_ni_pkg.sv
// minbd_local_ni shared types: extended flit layout, offer-FSM states, depth defaults.
// No logic; pure declarations.
// No flow control of its own.
package minbd_local_ni_pkg;

   // Extended flit as seen on the router local ports.
   typedef struct packed {
      logic        vld;
      logic        golden;
      logic [1:0]  dst_x;
      logic [1:0]  dst_y;
      logic [31:0] data;
   } flit_ext_t;

   localparam int WIDTH_FLIT_EXT = $bits(flit_ext_t);

   localparam int INJ_DEPTH_DEF = 4;
   localparam int EJ_DEPTH_DEF  = 8;

   // Injection offer FSM. The resolve cycle is OFR_OFFER with pending set.
   typedef enum logic [1:0] {
      OFR_IDLE  = 2'd0,
      OFR_OFFER = 2'd1,
      OFR_WAIT  = 2'd2
   } offer_state_e;

endpackage

// File: rtl/minbd_local_ni_dual_wr_fifo.sv
// FIFO with two ordered write ports (wr0 before wr1) and one read port.
// Latency: a write at cycle t is readable at t+1; free_cnt reflects start-of-cycle occupancy.
// Backpressure: none on writes - writes beyond free space are dropped and flagged on drop.
module ni_dual_wr_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     wr0_vld,
   input  logic [W-1:0]             wr0_dat,
   input  logic                     wr1_vld,
   input  logic [W-1:0]             wr1_dat,
   output logic                     rd_vld,
   output logic [W-1:0]             rd_dat,
   output logic [W-1:0]             rd_nxt_dat,
   input  logic                     rd_rdy,
   output logic [$clog2(DEPTH):0]   free_cnt,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW:0]   wptr_q, wptr_d;
   logic [AW:0]   rptr_q, rptr_d;
   logic [AW:0]   used;
   logic [AW:0]   room;
   logic [AW-1:0] rd_idx_nxt;

   // Pointers carry a wrap bit: equal index with differing wrap bit is full,
   // which is exactly free_cnt == 0.
   assign used       = wptr_q - rptr_q;
   assign free_cnt   = DEPTH_L - used;
   assign rd_vld     = (wptr_q != rptr_q);
   assign rd_dat     = mem_q[rptr_q[AW-1:0]];
   assign rd_idx_nxt = rptr_q[AW-1:0] + AW'(1);
   assign rd_nxt_dat = mem_q[rd_idx_nxt];

   // Compact valid writes in port order into the space free at cycle start.
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      drop   = 1'b0;
      room   = free_cnt;
      if (wr0_vld) begin
         if (room != '0) begin
            mem_d[wptr_d[AW-1:0]] = wr0_dat;
            wptr_d = wptr_d + (AW+1)'(1);
            room   = room - (AW+1)'(1);
         end else begin
            drop = 1'b1;
         end
      end
      if (wr1_vld) begin
         if (room != '0) begin
            mem_d[wptr_d[AW-1:0]] = wr1_dat;
            wptr_d = wptr_d + (AW+1)'(1);
         end else begin
            drop = 1'b1;
         end
      end
      if (rd_rdy && rd_vld) begin
         rptr_d = rptr_q + (AW+1)'(1);
      end
   end

   // Storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

endmodule

// File: rtl/minbd_local_ni.sv
// minBD local NI: core injection queue with stop-and-wait offer to din_l, dual-port ejection queue to core.
// Latency: push->offer 1 cycle when idle, grant sampled 2 cycles after offer; eject->core 1 cycle.
// Backpressure: core_inj_rdy on injection full; ejection never stalls, drops set sticky ej_overflow. Option: NI_STARVE_CNT_EN.
module minbd_local_ni
   import minbd_local_ni_pkg::*;
#(
   parameter int INJ_DEPTH = INJ_DEPTH_DEF,
   parameter int EJ_DEPTH  = EJ_DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      core_inj_vld,
   input  logic [WIDTH_FLIT_EXT-1:0] core_inj_flit,
   output logic                      core_inj_rdy,
   output flit_ext_t                 din_l,
   input  logic                      local_inject_gnt,
   input  flit_ext_t                 dout_l_1,
   input  flit_ext_t                 dout_l_2,
   output logic                      core_ej_vld,
   output flit_ext_t                 core_ej_flit,
   input  logic                      core_ej_rdy,
   output logic                      ej_overflow,
   output logic [7:0]                inj_starve_cnt
);

   localparam int IAW = $clog2(INJ_DEPTH);
   localparam int EAW = $clog2(EJ_DEPTH);

   offer_state_e state_q, state_d;
   logic         pending_q, pending_d;
   logic         ej_overflow_q, ej_overflow_d;

   flit_ext_t    inj_wr_flit;
   flit_ext_t    inj_head;
   flit_ext_t    inj_next;
   logic         inj_push;
   logic         inj_pop;
   logic         inj_vld;
   logic         inj_more;
   logic [IAW:0] inj_free;
   logic         inj_drop_unused;

   logic [EAW:0] ej_free_unused;
   flit_ext_t    ej_nxt_unused;
   logic         ej_drop;

   // ---------------- injection ----------------

   assign core_inj_rdy = n_rst && (inj_free != '0);
   assign inj_push     = core_inj_vld && core_inj_rdy;
   // More than one entry queued, so a granted head has a successor to offer.
   assign inj_more     = (inj_free < (IAW+1)'(INJ_DEPTH - 1));

   // Core-supplied vld/golden are never stored.
   always_comb begin
      inj_wr_flit        = flit_ext_t'(core_inj_flit);
      inj_wr_flit.vld    = 1'b0;
      inj_wr_flit.golden = 1'b0;
   end

   ni_dual_wr_fifo #(
      .W     (WIDTH_FLIT_EXT),
      .DEPTH (INJ_DEPTH)
   ) u_inj_fifo (
      .clk        (clk),
      .n_rst      (n_rst),
      .wr0_vld    (inj_push),
      .wr0_dat    (inj_wr_flit),
      .wr1_vld    (1'b0),
      .wr1_dat    ('0),
      .rd_vld     (inj_vld),
      .rd_dat     (inj_head),
      .rd_nxt_dat (inj_next),
      .rd_rdy     (inj_pop),
      .free_cnt   (inj_free),
      .drop       (inj_drop_unused)
   );

   // Offer FSM: OFFER drives the head for one cycle, WAIT hides it, the following
   // OFFER (pending set) resolves the grant and either re-offers or moves on.
   always_comb begin
      state_d    = state_q;
      pending_d  = 1'b0;
      inj_pop    = 1'b0;
      din_l        = inj_head;
      din_l.vld    = 1'b0;
      din_l.golden = 1'b0;
      case (state_q)
         OFR_IDLE: begin
            if (inj_vld || inj_push) begin
               state_d = OFR_OFFER;
            end
         end
         OFR_OFFER: begin
            if (pending_q && local_inject_gnt) begin
               inj_pop = 1'b1;
               if (inj_more) begin
                  din_l        = inj_next;
                  din_l.vld    = 1'b1;
                  din_l.golden = 1'b0;
                  state_d      = OFR_WAIT;
               end else if (inj_push) begin
                  state_d = OFR_OFFER;
               end else begin
                  state_d = OFR_IDLE;
               end
            end else begin
               din_l.vld = 1'b1;
               state_d   = OFR_WAIT;
            end
         end
         OFR_WAIT: begin
            pending_d = 1'b1;
            state_d   = OFR_OFFER;
         end
         default: begin
            state_d = OFR_IDLE;
         end
      endcase
   end

   // Offer FSM state and grant-qualifier registers.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q   <= OFR_IDLE;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

`ifdef NI_STARVE_CNT_EN
   logic [7:0] starve_q, starve_d;

   // Count consecutive denied resolves, saturating; a granted resolve clears it.
   always_comb begin
      starve_d = starve_q;
      if (state_q == OFR_OFFER && pending_q) begin
         if (local_inject_gnt) begin
            starve_d = '0;
         end else if (starve_q != 8'hFF) begin
            starve_d = starve_q + 8'd1;
         end
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign inj_starve_cnt = starve_q;
`else
   assign inj_starve_cnt = 8'd0;
`endif

   // ---------------- ejection ----------------

   ni_dual_wr_fifo #(
      .W     (WIDTH_FLIT_EXT),
      .DEPTH (EJ_DEPTH)
   ) u_ej_fifo (
      .clk        (clk),
      .n_rst      (n_rst),
      .wr0_vld    (dout_l_1.vld),
      .wr0_dat    (dout_l_1),
      .wr1_vld    (dout_l_2.vld),
      .wr1_dat    (dout_l_2),
      .rd_vld     (core_ej_vld),
      .rd_dat     (core_ej_flit),
      .rd_nxt_dat (ej_nxt_unused),
      .rd_rdy     (core_ej_rdy),
      .free_cnt   (ej_free_unused),
      .drop       (ej_drop)
   );

   // Overflow is sticky until reset.
   always_comb begin
      ej_overflow_d = ej_overflow_q | ej_drop;
   end

   // Overflow flag register.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         ej_overflow_q <= 1'b0;
      end else begin
         ej_overflow_q <= ej_overflow_d;
      end
   end

   assign ej_overflow = ej_overflow_q;

endmodule

// File: tb/tb_minbd_local_ni.sv
// Bench for minbd_local_ni: scoreboards for injection offers and ejection output.
// Inputs driven at negedge, outputs sampled 1 time unit later.
// Counter expectations follow NI_STARVE_CNT_EN when defined.
module tb_minbd_local_ni;
   import minbd_local_ni_pkg::*;

`ifdef NI_STARVE_CNT_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       n_rst;
   logic       core_inj_vld;
   flit_ext_t  core_inj_flit;
   logic       core_inj_rdy;
   flit_ext_t  din_l;
   logic       local_inject_gnt;
   flit_ext_t  dout_l_1;
   flit_ext_t  dout_l_2;
   logic       core_ej_vld;
   flit_ext_t  core_ej_flit;
   logic       core_ej_rdy;
   logic       ej_overflow;
   logic [7:0] inj_starve_cnt;

   int total = 0;
   int bad   = 0;

   flit_ext_t sb_inj[$];
   flit_ext_t sb_ej[$];

   always #5 clk = ~clk;

   minbd_local_ni #(.INJ_DEPTH(4), .EJ_DEPTH(8)) dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .core_inj_vld     (core_inj_vld),
      .core_inj_flit    (core_inj_flit),
      .core_inj_rdy     (core_inj_rdy),
      .din_l            (din_l),
      .local_inject_gnt (local_inject_gnt),
      .dout_l_1         (dout_l_1),
      .dout_l_2         (dout_l_2),
      .core_ej_vld      (core_ej_vld),
      .core_ej_flit     (core_ej_flit),
      .core_ej_rdy      (core_ej_rdy),
      .ej_overflow      (ej_overflow),
      .inj_starve_cnt   (inj_starve_cnt)
   );

   function automatic flit_ext_t mk_inj(input int i, input logic [1:0] x, input logic [1:0] y);
      flit_ext_t f;
      f.vld    = 1'b1;
      f.golden = 1'b1;
      f.dst_x  = x;
      f.dst_y  = y;
      f.data   = 32'hA000_0000 + 32'(i);
      return f;
   endfunction

   function automatic flit_ext_t exp_offer(input flit_ext_t f);
      flit_ext_t e;
      e        = f;
      e.vld    = 1'b1;
      e.golden = 1'b0;
      return e;
   endfunction

   function automatic flit_ext_t mk_ej(input int i);
      flit_ext_t f;
      f.vld    = 1'b1;
      f.golden = i[0];
      f.dst_x  = i[1:0];
      f.dst_y  = i[3:2];
      f.data   = 32'hE000_0000 + 32'(i);
      return f;
   endfunction

   task automatic idle_inputs();
      core_inj_vld     = 1'b0;
      core_inj_flit    = '0;
      local_inject_gnt = 1'b0;
      dout_l_1         = '0;
      dout_l_2         = '0;
      core_ej_rdy      = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      idle_inputs();
      n_rst = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      sb_inj.delete();
      sb_ej.delete();
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (core_inj_rdy !== 1'b0) begin
         bad++; $display("FAIL reset_inj_rdy_low got=%0b exp=0", core_inj_rdy);
      end
      @(negedge clk);
      n_rst = 1'b1;
      #1;
      total++;
      if (core_inj_rdy !== 1'b1) begin
         bad++; $display("FAIL reset_inj_rdy got=%0b exp=1", core_inj_rdy);
      end
      total++;
      if (din_l.vld !== 1'b0) begin
         bad++; $display("FAIL reset_din_vld got=%0b exp=0", din_l.vld);
      end
      total++;
      if (core_ej_vld !== 1'b0) begin
         bad++; $display("FAIL reset_ej_vld got=%0b exp=0", core_ej_vld);
      end
      total++;
      if (ej_overflow !== 1'b0) begin
         bad++; $display("FAIL reset_overflow got=%0b exp=0", ej_overflow);
      end
      total++;
      if (inj_starve_cnt !== 8'd0) begin
         bad++; $display("FAIL reset_starve got=%0d exp=0", inj_starve_cnt);
      end
   endtask

   task automatic test_single_grant();
      flit_ext_t f;
      f = mk_inj(1, 2'd2, 2'd1);
      @(negedge clk);
      core_inj_vld  = 1'b1;
      core_inj_flit = f;
      sb_inj.push_back(exp_offer(f));
      #1;
      total++;
      if (core_inj_rdy !== 1'b1) begin
         bad++; $display("FAIL single_push_rdy got=%0b exp=1", core_inj_rdy);
      end
      // offer cycle
      @(negedge clk);
      core_inj_vld = 1'b0;
      #1;
      total++;
      if (sb_inj.size() == 0 || din_l !== sb_inj[0]) begin
         bad++; $display("FAIL single_offer got=%h exp=%h", din_l, exp_offer(f));
      end
      // wait cycle
      @(negedge clk);
      #1;
      total++;
      if (din_l.vld !== 1'b0 || din_l.golden !== 1'b0) begin
         bad++; $display("FAIL single_wait vld=%0b golden=%0b exp=0,0", din_l.vld, din_l.golden);
      end
      // resolve cycle, granted
      @(negedge clk);
      local_inject_gnt = 1'b1;
      if (sb_inj.size() != 0) void'(sb_inj.pop_front());
      #1;
      total++;
      if (din_l.vld !== 1'b0 || din_l.golden !== 1'b0) begin
         bad++; $display("FAIL single_resolve vld=%0b golden=%0b exp=0,0", din_l.vld, din_l.golden);
      end
      // popped: never offered again
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         local_inject_gnt = 1'b0;
         #1;
         total++;
         if (din_l.vld !== 1'b0) begin
            bad++; $display("FAIL single_idle_after_pop cyc=%0d got=%0b exp=0", c, din_l.vld);
         end
      end
   endtask

   task automatic test_deny_then_grant();
      flit_ext_t f;
      int offers;
      logic [7:0] exp_cnt;
      offers = 0;
      f = mk_inj(2, 2'd1, 2'd3);
      @(negedge clk);
      core_inj_vld  = 1'b1;
      core_inj_flit = f;
      sb_inj.push_back(exp_offer(f));
      @(negedge clk);
      core_inj_vld = 1'b0;
      #1;
      if (din_l.vld === 1'b1) offers++;
      total++;
      if (sb_inj.size() == 0 || din_l !== sb_inj[0]) begin
         bad++; $display("FAIL deny_first_offer got=%h exp=%h", din_l, exp_offer(f));
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         local_inject_gnt = 1'b0;
         #1;
         if (din_l.vld === 1'b1) offers++;
         exp_cnt = STARVE_ON ? 8'(k) : 8'd0;
         total++;
         if (din_l.vld !== 1'b0 || inj_starve_cnt !== exp_cnt) begin
            bad++; $display("FAIL deny_wait k=%0d vld=%0b starve=%0d exp_vld=0 exp_starve=%0d", k, din_l.vld, inj_starve_cnt, exp_cnt);
         end
         @(negedge clk);
         local_inject_gnt = (k == 3);
         if (k == 3 && sb_inj.size() != 0) void'(sb_inj.pop_front());
         #1;
         if (din_l.vld === 1'b1) offers++;
         total++;
         if (k < 3) begin
            if (sb_inj.size() == 0 || din_l !== sb_inj[0]) begin
               bad++; $display("FAIL deny_reoffer k=%0d got=%h exp=%h", k, din_l, exp_offer(f));
            end
         end else if (din_l.vld !== 1'b0) begin
            bad++; $display("FAIL deny_granted_resolve got_vld=%0b exp=0", din_l.vld);
         end
      end
      @(negedge clk);
      local_inject_gnt = 1'b0;
      #1;
      if (din_l.vld === 1'b1) offers++;
      total++;
      if (inj_starve_cnt !== 8'd0 || din_l.vld !== 1'b0) begin
         bad++; $display("FAIL deny_after_grant starve=%0d vld=%0b exp=0,0", inj_starve_cnt, din_l.vld);
      end
      total++;
      if (offers != 4) begin
         bad++; $display("FAIL deny_offer_count got=%0d exp=4", offers);
      end
   endtask

   task automatic test_inj_full();
      int   age;
      logic exp_rdy;
      flit_ext_t f;
      age = 99;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         age++;
         if (cyc < 5) begin
            f = mk_inj(10 + cyc, 2'(cyc), 2'd0);
            core_inj_vld  = 1'b1;
            core_inj_flit = f;
            if (cyc < 4) sb_inj.push_back(exp_offer(f));
         end else if (cyc > 5) begin
            core_inj_vld = 1'b0;
         end
         local_inject_gnt = (cyc >= 6) && (age == 2);
         if (local_inject_gnt && sb_inj.size() != 0) void'(sb_inj.pop_front());
         #1;
         if (cyc <= 5) begin
            exp_rdy = (cyc < 4);
            total++;
            if (core_inj_rdy !== exp_rdy) begin
               bad++; $display("FAIL full_inj_rdy cyc=%0d got=%0b exp=%0b", cyc, core_inj_rdy, exp_rdy);
            end
         end
         if (din_l.vld === 1'b1) begin
            age = 0;
            total++;
            if (sb_inj.size() == 0 || din_l !== sb_inj[0]) begin
               bad++; $display("FAIL full_offer cyc=%0d got=%h exp_left=%0d", cyc, din_l, sb_inj.size());
            end
         end
         if (cyc >= 6 && sb_inj.size() == 0 && age > 4) break;
      end
      local_inject_gnt = 1'b0;
      core_inj_vld     = 1'b0;
      total++;
      if (sb_inj.size() != 0) begin
         bad++; $display("FAIL full_drain_timeout left=%0d exp=0", sb_inj.size());
      end
   endtask

   task automatic drain_ej(input string name);
      for (int c = 0; c < 30 && sb_ej.size() != 0; c++) begin
         @(negedge clk);
         core_ej_rdy = 1'b1;
         #1;
         if (core_ej_vld === 1'b1) begin
            total++;
            if (core_ej_flit !== sb_ej[0]) begin
               bad++; $display("FAIL %s_data got=%h exp=%h", name, core_ej_flit, sb_ej[0]);
            end
            void'(sb_ej.pop_front());
         end
      end
      total++;
      if (sb_ej.size() != 0) begin
         bad++; $display("FAIL %s_timeout left=%0d exp=0", name, sb_ej.size());
      end
      @(negedge clk);
      core_ej_rdy = 1'b0;
      #1;
      total++;
      if (core_ej_vld !== 1'b0) begin
         bad++; $display("FAIL %s_empty got_vld=%0b exp=0", name, core_ej_vld);
      end
   endtask

   task automatic test_ej_full();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         core_ej_rdy = 1'b0;
         dout_l_1 = mk_ej(2 * c);
         dout_l_2 = mk_ej(2 * c + 1);
         if (c < 4) begin
            sb_ej.push_back(dout_l_1);
            sb_ej.push_back(dout_l_2);
         end
         #1;
         if (c == 1) begin
            total++;
            if (core_ej_vld !== 1'b1 || core_ej_flit !== mk_ej(0)) begin
               bad++; $display("FAIL ej_first_latency vld=%0b got=%h exp=%h", core_ej_vld, core_ej_flit, mk_ej(0));
            end
         end
         if (c == 4) begin
            total++;
            if (ej_overflow !== 1'b0) begin
               bad++; $display("FAIL ej_overflow_early got=%0b exp=0", ej_overflow);
            end
         end
      end
      @(negedge clk);
      dout_l_1 = '0;
      dout_l_2 = '0;
      #1;
      total++;
      if (ej_overflow !== 1'b1) begin
         bad++; $display("FAIL ej_overflow_set got=%0b exp=1", ej_overflow);
      end
      drain_ej("ej_full");
      total++;
      if (ej_overflow !== 1'b1) begin
         bad++; $display("FAIL ej_overflow_sticky got=%0b exp=1", ej_overflow);
      end
   endtask

   task automatic test_ej_partial();
      pulse_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         dout_l_1 = (c == 3) ? flit_ext_t'('0) : mk_ej(20 + 2 * c);
         dout_l_2 = mk_ej(21 + 2 * c);
         if (dout_l_1.vld) sb_ej.push_back(dout_l_1);
         if (c < 4) sb_ej.push_back(dout_l_2);
         #1;
         if (c == 4) begin
            total++;
            if (ej_overflow !== 1'b0) begin
               bad++; $display("FAIL partial_overflow_early got=%0b exp=0", ej_overflow);
            end
         end
      end
      @(negedge clk);
      dout_l_1 = '0;
      dout_l_2 = '0;
      #1;
      total++;
      if (ej_overflow !== 1'b1) begin
         bad++; $display("FAIL partial_overflow_set got=%0b exp=1", ej_overflow);
      end
      drain_ej("ej_partial");
   endtask

   task automatic test_ej_stream();
      pulse_reset();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         core_ej_rdy = 1'b1;
         dout_l_1 = '0;
         dout_l_2 = '0;
         if (c < 8) begin
            if (c % 3 != 1) dout_l_1 = mk_ej(40 + 2 * c);
            if (c % 2 == 0) dout_l_2 = mk_ej(41 + 2 * c);
            if (dout_l_1.vld) sb_ej.push_back(dout_l_1);
            if (dout_l_2.vld) sb_ej.push_back(dout_l_2);
         end
         #1;
         if (core_ej_vld === 1'b1) begin
            total++;
            if (sb_ej.size() == 0 || core_ej_flit !== sb_ej[0]) begin
               bad++; $display("FAIL stream_data cyc=%0d got=%h left=%0d", c, core_ej_flit, sb_ej.size());
            end
            if (sb_ej.size() != 0) void'(sb_ej.pop_front());
         end
         if (c >= 8 && sb_ej.size() == 0) break;
      end
      core_ej_rdy = 1'b0;
      dout_l_1 = '0;
      dout_l_2 = '0;
      total++;
      if (sb_ej.size() != 0 || ej_overflow !== 1'b0) begin
         bad++; $display("FAIL stream_end left=%0d overflow=%0b exp=0,0", sb_ej.size(), ej_overflow);
      end
   endtask

   task automatic test_reset_mid();
      flit_ext_t f;
      f = mk_inj(30, 2'd3, 2'd2);
      @(negedge clk);
      core_inj_vld  = 1'b1;
      core_inj_flit = f;
      dout_l_1      = mk_ej(99);
      @(negedge clk);
      core_inj_vld = 1'b0;
      dout_l_1     = '0;
      #1;
      total++;
      if (din_l !== exp_offer(f)) begin
         bad++; $display("FAIL mid_offer got=%h exp=%h", din_l, exp_offer(f));
      end
      // WAIT cycle: reset here
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      total++;
      if (core_inj_rdy !== 1'b0) begin
         bad++; $display("FAIL mid_rdy_in_reset got=%0b exp=0", core_inj_rdy);
      end
      @(negedge clk);
      n_rst = 1'b1;
      local_inject_gnt = 1'b1;
      sb_inj.delete();
      sb_ej.delete();
      #1;
      total++;
      if (din_l.vld !== 1'b0 || core_ej_vld !== 1'b0 || ej_overflow !== 1'b0 ||
          inj_starve_cnt !== 8'd0 || core_inj_rdy !== 1'b1) begin
         bad++; $display("FAIL mid_reset_vals din=%0b ej=%0b ovf=%0b st=%0d rdy=%0b exp=0,0,0,0,1",
                         din_l.vld, core_ej_vld, ej_overflow, inj_starve_cnt, core_inj_rdy);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         local_inject_gnt = 1'b0;
         #1;
         total++;
         if (din_l.vld !== 1'b0 || core_ej_vld !== 1'b0) begin
            bad++; $display("FAIL mid_stays_empty cyc=%0d din=%0b ej=%0b exp=0,0", c, din_l.vld, core_ej_vld);
         end
      end
      f = mk_inj(31, 2'd0, 2'd1);
      @(negedge clk);
      core_inj_vld  = 1'b1;
      core_inj_flit = f;
      @(negedge clk);
      core_inj_vld = 1'b0;
      #1;
      total++;
      if (din_l !== exp_offer(f)) begin
         bad++; $display("FAIL mid_new_offer got=%h exp=%h", din_l, exp_offer(f));
      end
      @(negedge clk);
      @(negedge clk);
      local_inject_gnt = 1'b1;
      @(negedge clk);
      local_inject_gnt = 1'b0;
      #1;
      total++;
      if (din_l.vld !== 1'b0) begin
         bad++; $display("FAIL mid_new_granted got=%0b exp=0", din_l.vld);
      end
   endtask

   initial begin
      test_reset();
      test_single_grant();
      test_deny_then_grant();
      test_inj_full();
      test_ej_full();
      test_ej_partial();
      test_ej_stream();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
